memory_stage: RTL and testbench

- MEM stage of the 5-stage pipelined MIPS core; consumes the registered outputs of the execute latch.
- Issues data-cache read/write requests and stalls the pipeline until dhit.
- Resolves branches and jumps, and drives PC redirect and flush.
- Owns the MEM/WB pipeline register and a halt tracker, and keeps access/stall performance counters.

---
 rtl/memory_stage.sv | 161 ++++++++++++++++
 tb/tb_memory_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the 5-stage pipelined MIPS core.
//
// Consumes the registered outputs of the EX/MEM latch, issues data-cache
// read/write requests and holds the front of the pipeline (mem_stall) until
// the cache answers with dhit. Resolves branches/jumps into a PC redirect,
// owns the MEM/WB pipeline register, tracks a sticky halt and keeps two
// saturating performance counters.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   ex_*                     EX/MEM latch outputs (data + control)
//   dhit, dmemload           cache completion and read data
//   dmemREN/WEN/addr/store   cache request
//   mem_stall                freezes PC and IF/ID, ID/EX, EX/MEM latches
//   redirect, redirect_addr  PC reload + flush of the younger latches
//   wb_regWEN/wsel/wdat      MEM/WB register contents
//   wb_halt                  sticky registered halt to the top level
//   access_cnt, stall_cnt    completed accesses / stalled cycles (saturating)

module memory_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      ex_pc_plus_4,
  input  logic [31:0]      ex_baddr,
  input  logic [31:0]      ex_jaddr,
  input  logic [31:0]      ex_portout,
  input  logic [31:0]      ex_rdat2,
  input  logic             ex_zero,
  input  logic             ex_Branch,
  input  logic             ex_bne,
  input  logic             ex_Jump,
  input  logic             ex_JAL,
  input  logic             ex_MemtoReg,
  input  logic             ex_dREN,
  input  logic             ex_dWEN,
  input  logic             ex_regWEN,
  input  logic             ex_halt,
  input  logic [4:0]       ex_wsel,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic             mem_stall,
  output logic             redirect,
  output logic [31:0]      redirect_addr,
  output logic             wb_regWEN,
  output logic [4:0]       wb_wsel,
  output logic [31:0]      wb_wdat,
  output logic             wb_halt,
  output logic [CNT_W-1:0] access_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StHalted
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e      state_q;
  logic        halted;
  logic        req;
  logic        taken;
  logic        halt_take;
  logic [31:0] wb_wdat_d;

  // Request, stall and redirect generation. The EX/MEM latch is frozen by
  // mem_stall, so the request stays stable until dhit without local holding.
  always_comb begin
    halted        = (state_q == StHalted);
    req           = (ex_dREN | ex_dWEN) & ~halted;
    dmemWEN       = ex_dWEN & ~halted;
    // A write wins when both enables are set.
    dmemREN       = ex_dREN & ~ex_dWEN & ~halted;
    dmemaddr      = ex_portout;
    dmemstore     = ex_rdat2;
    mem_stall     = req & ~dhit;
    taken         = ex_Branch & (ex_zero ^ ex_bne);
    // No redirect while stalled: the branch is re-evaluated once the
    // access completes, and the frozen latches must not be flushed early.
    redirect      = (taken | ex_Jump) & ~mem_stall & ~halted;
    redirect_addr = ex_Jump ? ex_jaddr : ex_baddr;
    // Halt only retires in a non-stalled cycle so a paired access finishes.
    halt_take     = ex_halt & ~mem_stall & ~halted;
  end

  // Write-back data selection: link address, load data or ALU result.
  always_comb begin
    wb_wdat_d = ex_portout;
    if (ex_JAL) begin
      wb_wdat_d = ex_pc_plus_4;
    end else if (ex_MemtoReg) begin
      wb_wdat_d = dmemload;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      wb_regWEN  <= 1'b0;
      wb_wsel    <= 5'd0;
      wb_wdat    <= 32'd0;
      wb_halt    <= 1'b0;
      access_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      // Control state
      unique case (state_q)
        StIdle: begin
          if (halt_take) begin
            state_q <= StHalted;
          end else if (mem_stall) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (halt_take) begin
            state_q <= StHalted;
          end else if (dhit) begin
            state_q <= StIdle;
          end
        end
        StHalted: state_q <= StHalted;
        default:  state_q <= StIdle;
      endcase

      // MEM/WB register
      if (halted) begin
        wb_regWEN <= 1'b0;
        wb_halt   <= 1'b1;
      end else if (mem_stall) begin
        // Bubble: suppress the write and the halt, hold destination/data.
        wb_regWEN <= 1'b0;
        wb_halt   <= 1'b0;
      end else begin
        wb_regWEN <= ex_regWEN;
        wb_wsel   <= ex_wsel;
        wb_wdat   <= wb_wdat_d;
        wb_halt   <= ex_halt;
      end

      // Performance counters, frozen once halted
      if (!halted) begin
        if (req && dhit && access_cnt != CntMax) begin
          access_cnt <= access_cnt + CntOne;
        end
        if (mem_stall && stall_cnt != CntMax) begin
          stall_cnt <= stall_cnt + CntOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: table of combinational vectors, directed
// multi-cycle sequences, and randomized cycles against a reference model.

module tb_memory_stage;

  localparam int unsigned CW = 8;
  localparam int CntSat = (1 << CW) - 1;

  logic          CLK, RST;
  logic [31:0]   ex_pc_plus_4, ex_baddr, ex_jaddr, ex_portout, ex_rdat2;
  logic          ex_zero, ex_Branch, ex_bne, ex_Jump, ex_JAL, ex_MemtoReg;
  logic          ex_dREN, ex_dWEN, ex_regWEN, ex_halt;
  logic [4:0]    ex_wsel;
  logic          dhit;
  logic [31:0]   dmemload;
  logic          dmemREN, dmemWEN, mem_stall, redirect;
  logic [31:0]   dmemaddr, dmemstore, redirect_addr;
  logic          wb_regWEN, wb_halt;
  logic [4:0]    wb_wsel;
  logic [31:0]   wb_wdat;
  logic [CW-1:0] access_cnt, stall_cnt;

  memory_stage #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .ex_pc_plus_4(ex_pc_plus_4), .ex_baddr(ex_baddr), .ex_jaddr(ex_jaddr),
    .ex_portout(ex_portout), .ex_rdat2(ex_rdat2), .ex_zero(ex_zero),
    .ex_Branch(ex_Branch), .ex_bne(ex_bne), .ex_Jump(ex_Jump), .ex_JAL(ex_JAL),
    .ex_MemtoReg(ex_MemtoReg), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
    .ex_regWEN(ex_regWEN), .ex_halt(ex_halt), .ex_wsel(ex_wsel),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .redirect(redirect), .redirect_addr(redirect_addr),
    .wb_regWEN(wb_regWEN), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat), .wb_halt(wb_halt),
    .access_cnt(access_cnt), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    ex_pc_plus_4 = 0; ex_baddr = 0; ex_jaddr = 0; ex_portout = 0; ex_rdat2 = 0;
    ex_zero = 0; ex_Branch = 0; ex_bne = 0; ex_Jump = 0; ex_JAL = 0; ex_MemtoReg = 0;
    ex_dREN = 0; ex_dWEN = 0; ex_regWEN = 0; ex_halt = 0; ex_wsel = 0;
    dhit = 0; dmemload = 0;
  endtask

  task automatic do_reset();
    clr();
    RST = 1'b1;
    #3;
    RST = 1'b0;
    #1;
  endtask

  // Reference model: pipeline-level view of the stage.
  bit          m_halted;
  int          m_acc, m_stl;
  bit          m_regwen, m_whalt;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat;

  task automatic m_reset();
    m_halted = 0; m_acc = 0; m_stl = 0;
    m_regwen = 0; m_whalt = 0; m_wsel = 0; m_wdat = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".wb_regWEN"}, 32'(wb_regWEN), 32'(m_regwen));
    chk({tag, ".wb_wsel"}, 32'(wb_wsel), 32'(m_wsel));
    chk({tag, ".wb_wdat"}, wb_wdat, m_wdat);
    chk({tag, ".wb_halt"}, 32'(wb_halt), 32'(m_whalt));
    chk({tag, ".access_cnt"}, 32'(access_cnt), 32'(m_acc));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stl));
  endtask

  typedef struct {
    logic        dren, dwen, hit, br, bne, zero, jmp;
    logic [31:0] baddr, jaddr;
    logic        e_ren, e_wen, e_stall, e_redir;
    logic [31:0] e_raddr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int acc_frozen, stl_frozen;
    vecs[0] = '{1, 0, 1, 0, 0, 0, 0, 32'h40, 32'h200, 1, 0, 0, 0, 32'h40};
    vecs[1] = '{0, 1, 0, 0, 0, 0, 0, 32'h40, 32'h200, 0, 1, 1, 0, 32'h40};
    vecs[2] = '{1, 1, 1, 0, 0, 0, 0, 32'h40, 32'h200, 0, 1, 0, 0, 32'h40};
    vecs[3] = '{0, 0, 0, 1, 1, 0, 0, 32'h40, 32'h200, 0, 0, 0, 1, 32'h40};
    vecs[4] = '{0, 0, 0, 1, 1, 1, 0, 32'h40, 32'h200, 0, 0, 0, 0, 32'h40};
    vecs[5] = '{0, 0, 0, 1, 0, 1, 0, 32'h80, 32'h200, 0, 0, 0, 1, 32'h80};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 1, 32'h40, 32'h200, 0, 0, 0, 1, 32'h200};
    vecs[7] = '{1, 0, 0, 1, 1, 0, 0, 32'h40, 32'h200, 1, 0, 1, 0, 32'h40};
    vecs[8] = '{0, 0, 0, 1, 0, 1, 1, 32'h44, 32'h300, 0, 0, 0, 1, 32'h300};
    vecs[9] = '{0, 0, 1, 0, 0, 0, 0, 32'h10, 32'h20, 0, 0, 0, 0, 32'h10};

    RST = 1'b0;
    clr();
    #2;
    RST = 1'b1;
    #2;
    // Reset state
    m_reset();
    chk_regs("reset");
    chk("reset.dmemREN", 32'(dmemREN), 0);
    chk("reset.mem_stall", 32'(mem_stall), 0);
    chk("reset.redirect", 32'(redirect), 0);
    RST = 1'b0;
    cyc();

    // Combinational vectors
    foreach (vecs[i]) begin
      ex_dREN = vecs[i].dren; ex_dWEN = vecs[i].dwen; dhit = vecs[i].hit;
      ex_Branch = vecs[i].br; ex_bne = vecs[i].bne; ex_zero = vecs[i].zero;
      ex_Jump = vecs[i].jmp; ex_baddr = vecs[i].baddr; ex_jaddr = vecs[i].jaddr;
      #1;
      chk($sformatf("vec%0d.dmemREN", i), 32'(dmemREN), 32'(vecs[i].e_ren));
      chk($sformatf("vec%0d.dmemWEN", i), 32'(dmemWEN), 32'(vecs[i].e_wen));
      chk($sformatf("vec%0d.mem_stall", i), 32'(mem_stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d.redirect", i), 32'(redirect), 32'(vecs[i].e_redir));
      chk($sformatf("vec%0d.redirect_addr", i), redirect_addr, vecs[i].e_raddr);
    end

    // Zero-wait load
    do_reset();
    ex_dREN = 1; ex_portout = 32'h100; ex_MemtoReg = 1; ex_regWEN = 1; ex_wsel = 8;
    dhit = 1; dmemload = 32'hDEADBEEF;
    #1;
    chk("zwl.dmemREN", 32'(dmemREN), 1);
    chk("zwl.dmemaddr", dmemaddr, 32'h100);
    chk("zwl.mem_stall", 32'(mem_stall), 0);
    cyc();
    clr();
    chk("zwl.wb_wdat", wb_wdat, 32'hDEADBEEF);
    chk("zwl.wb_regWEN", 32'(wb_regWEN), 1);
    chk("zwl.wb_wsel", 32'(wb_wsel), 8);
    chk("zwl.access_cnt", 32'(access_cnt), 1);

    // Miss store: three wait cycles
    do_reset();
    ex_dWEN = 1; ex_rdat2 = 32'h1234; ex_regWEN = 1; ex_wsel = 3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("miss.stall%0d", k), 32'(mem_stall), 1);
      chk($sformatf("miss.store%0d", k), dmemstore, 32'h1234);
      chk($sformatf("miss.wen%0d", k), 32'(dmemWEN), 1);
      cyc();
      chk($sformatf("miss.bubble%0d", k), 32'(wb_regWEN), 0);
    end
    dhit = 1;
    #1;
    chk("miss.stall_done", 32'(mem_stall), 0);
    cyc();
    clr();
    chk("miss.stall_cnt", 32'(stall_cnt), 3);
    chk("miss.access_cnt", 32'(access_cnt), 1);
    chk("miss.wb_regWEN", 32'(wb_regWEN), 1);
    chk("miss.wb_wsel", 32'(wb_wsel), 3);

    // dhit with no request is ignored
    dhit = 1;
    cyc(); cyc();
    chk("idlehit.access_cnt", 32'(access_cnt), 1);
    chk("idlehit.stall_cnt", 32'(stall_cnt), 3);
    clr();

    // JAL
    ex_Jump = 1; ex_JAL = 1; ex_jaddr = 32'h200; ex_pc_plus_4 = 32'h14; ex_wsel = 31;
    ex_regWEN = 1; ex_baddr = 32'h40; ex_portout = 32'h77;
    #1;
    chk("jal.redirect", 32'(redirect), 1);
    chk("jal.redirect_addr", redirect_addr, 32'h200);
    cyc();
    clr();
    chk("jal.wb_wdat", wb_wdat, 32'h14);
    chk("jal.wb_wsel", 32'(wb_wsel), 31);

    // Halt paired with a missing load: access completes first
    do_reset();
    ex_halt = 1; ex_dREN = 1; dhit = 0;
    cyc();
    chk("halt.pending_wb_halt", 32'(wb_halt), 0);
    dhit = 1;
    cyc();
    clr();
    chk("halt.wb_halt", 32'(wb_halt), 1);
    chk("halt.access_cnt", 32'(access_cnt), 1);
    acc_frozen = int'(access_cnt);
    stl_frozen = int'(stall_cnt);
    ex_dREN = 1; ex_Branch = 1; ex_bne = 1; ex_regWEN = 1; dhit = 0;
    #1;
    chk("halt.dmemREN", 32'(dmemREN), 0);
    chk("halt.redirect", 32'(redirect), 0);
    chk("halt.mem_stall", 32'(mem_stall), 0);
    cyc(); cyc();
    dhit = 1;
    cyc();
    chk("halt.wb_halt_sticky", 32'(wb_halt), 1);
    chk("halt.wb_regWEN", 32'(wb_regWEN), 0);
    chk("halt.access_frozen", 32'(access_cnt), 32'(acc_frozen));
    chk("halt.stall_frozen", 32'(stall_cnt), 32'(stl_frozen));
    #2;
    RST = 1;
    #1;
    chk("halt.async_clear", 32'(wb_halt), 0);
    RST = 0;
    clr();

    // Reset mid-WAIT
    cyc();
    ex_dREN = 1; dhit = 0; ex_regWEN = 1; ex_wsel = 9;
    cyc(); cyc();
    chk("rstwait.stall_cnt_pre", 32'(stall_cnt), 2);
    #2;
    clr();
    RST = 1;
    #1;
    chk("rstwait.stall_cnt", 32'(stall_cnt), 0);
    chk("rstwait.mem_stall", 32'(mem_stall), 0);
    chk("rstwait.dmemREN", 32'(dmemREN), 0);
    m_reset();
    chk_regs("rstwait");
    RST = 0;
    // Back in IDLE: a fresh zero-wait access completes without stalling
    ex_dREN = 1; dhit = 1;
    #1;
    chk("rstwait.fresh_stall", 32'(mem_stall), 0);
    cyc();
    chk("rstwait.fresh_access", 32'(access_cnt), 1);

    // Counter saturation
    do_reset();
    ex_dREN = 1; dhit = 0;
    repeat (CntSat + 10) cyc();
    chk("sat.stall_cnt", 32'(stall_cnt), 32'(CntSat));
    dhit = 1;
    repeat (CntSat + 10) cyc();
    chk("sat.access_cnt", 32'(access_cnt), 32'(CntSat));
    chk("sat.stall_hold", 32'(stall_cnt), 32'(CntSat));

    // Randomized cycles against the model
    do_reset();
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          e_req, e_stall, e_taken, e_redir, e_ren, e_wen;
      logic [31:0] e_raddr, e_wdat;
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 150) == 0) begin
        RST = 1;
        #1;
        m_reset();
        chk_regs("rnd.reset");
        RST = 0;
      end
      ex_pc_plus_4 = $urandom; ex_baddr = $urandom; ex_jaddr = $urandom;
      ex_portout = $urandom; ex_rdat2 = $urandom; dmemload = $urandom;
      ex_wsel = 5'($urandom);
      ex_zero = 1'($urandom); ex_bne = 1'($urandom);
      ex_Branch = ($urandom_range(0, 3) == 0);
      ex_Jump = ($urandom_range(0, 5) == 0);
      ex_JAL = ex_Jump && ($urandom_range(0, 1) == 0);
      ex_MemtoReg = 1'($urandom);
      ex_dREN = ($urandom_range(0, 2) == 0);
      ex_dWEN = ($urandom_range(0, 3) == 0);
      ex_regWEN = 1'($urandom);
      ex_halt = ($urandom_range(0, 60) == 0);
      dhit = 1'($urandom);
      #1;
      e_req   = (ex_dREN || ex_dWEN) && !m_halted;
      e_stall = e_req && !dhit;
      e_taken = ex_Branch && (ex_zero != ex_bne);
      e_redir = (e_taken || ex_Jump) && !e_stall && !m_halted;
      e_raddr = ex_Jump ? ex_jaddr : ex_baddr;
      e_wen   = ex_dWEN && !m_halted;
      e_ren   = ex_dREN && !ex_dWEN && !m_halted;
      chk("rnd.dmemREN", 32'(dmemREN), 32'(e_ren));
      chk("rnd.dmemWEN", 32'(dmemWEN), 32'(e_wen));
      chk("rnd.dmemaddr", dmemaddr, ex_portout);
      chk("rnd.dmemstore", dmemstore, ex_rdat2);
      chk("rnd.mem_stall", 32'(mem_stall), 32'(e_stall));
      chk("rnd.redirect", 32'(redirect), 32'(e_redir));
      chk("rnd.redirect_addr", redirect_addr, e_raddr);
      // Model advances on the clock edge
      if (ex_JAL) e_wdat = ex_pc_plus_4;
      else if (ex_MemtoReg) e_wdat = dmemload;
      else e_wdat = ex_portout;
      if (m_halted) begin
        m_regwen = 0; m_whalt = 1;
      end else begin
        if (e_req && dhit && m_acc < CntSat) m_acc++;
        if (e_stall && m_stl < CntSat) m_stl++;
        if (e_stall) begin
          m_regwen = 0; m_whalt = 0;
        end else begin
          m_regwen = ex_regWEN; m_wsel = ex_wsel; m_wdat = e_wdat; m_whalt = ex_halt;
          if (ex_halt) m_halted = 1;
        end
      end
      cyc();
      chk_regs("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
